// File: rtl/if_fetch_buf_if.sv
// -----------------------------------------------------------------------------
// if_fetch_buf_if
//   Bundles the two handshake sides of the fetch buffer: the instruction
//   memory request/response bus and the instruction hand-off to decode.
//
//   Handshake semantics:
//     imem side : imem_req_o is a one-cycle strobe, one word per cycle, and
//                 the memory always takes it (back-pressure is applied by the
//                 fetch buffer withholding requests).
//                 imem_rvalid_i returns responses in request order,
//                 at least one cycle after the request.
//     decode    : an instruction moves on the clock edge at which
//                 inst_valid_o && id_ready_i. inst_o and inst_addr_o are
//                 meaningful only while inst_valid_o is high.
//
//   Modports:
//     master : the fetch buffer (drives requests and instructions)
//     slave  : the environment (memory + decode)
// -----------------------------------------------------------------------------
interface if_fetch_buf_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;

  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              id_ready_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output inst_valid_o,
    output inst_o,
    output inst_addr_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  inst_valid_o,
    input  inst_o,
    input  inst_addr_o,
    output id_ready_i
  );

endinterface

// File: rtl/if_fetch_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_buf
//   Instruction fetch stage sitting directly after the PC generator.
//   Every cycle it may issue one in-order read of pc_addr_i to instruction
//   memory, reserving a FIFO slot for it. Responses fill the oldest reserved
//   slot; the head slot, once filled, is offered to decode. A flush throws
//   away every slot and remembers how many responses are still in flight so
//   they can be discarded when they come back.
//
// Ports:
//   clk_100MHz     in   clock
//   arst_n         in   asynchronous active-low reset
//   pc_addr_i      in   current PC from the PC stage
//   flush_i        in   jump taken this cycle; discard everything fetched
//   hold_i         in   pipeline hold; no new requests while high
//   fetch_hold_o   out  to PC stage; 1 = PC must not advance
//   bus            --   if_fetch_buf_if.master: imem request/response and
//                       instruction valid/ready to decode
//   dbg_count_o    out  allocated FIFO entries
//   dbg_drop_cnt_o out  responses still to be discarded after a flush
//   dbg_unfilled_o out  allocated entries still waiting for data
//
// Parameters:
//   ADDR_W  instruction address width
//   DATA_W  instruction word width
//   DEPTH   FIFO entries (power of two, >= 2); also the cap on requests
//           outstanding at memory, stale ones included
// -----------------------------------------------------------------------------
module if_fetch_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_100MHz,
  input  logic                     arst_n,
  input  logic [ADDR_W-1:0]        pc_addr_i,
  input  logic                     flush_i,
  input  logic                     hold_i,
  output logic                     fetch_hold_o,
  if_fetch_buf_if.master           bus,
  output logic [$clog2(DEPTH):0]   dbg_count_o,
  output logic [$clog2(DEPTH):0]   dbg_drop_cnt_o,
  output logic [$clog2(DEPTH):0]   dbg_unfilled_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_filled;

  // rd_ptr: head (next to decode); wr_ptr: next slot to allocate;
  // fill_ptr: oldest allocated slot still waiting for its response.
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  fill_ptr;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  unfilled;
  logic [CNT_W-1:0]  drop_cnt;

  // Low through the first edge after reset release so no request leaves
  // while reset is still settling.
  logic              run_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic              pop;
  logic              issue;
  logic              fill;
  logic              drop;
  logic              head_filled;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W-1:0]  stale_sum;
  logic [CNT_W-1:0]  flush_drop;

  always_comb begin
    head_filled = ent_filled[rd_ptr];
    pop         = head_filled & !flush_i & bus.id_ready_i;

    // Stale responses still occupy memory-side capacity, so they count
    // against the outstanding limit. pop <= count always holds because a
    // pop needs a filled head entry.
    occupancy = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {1'b0, drop_cnt};
    issue     = run_q & !flush_i & !hold_i & (occupancy < (CNT_W+1)'(DEPTH));

    drop = bus.imem_rvalid_i & (drop_cnt != '0);
    fill = bus.imem_rvalid_i & (drop_cnt == '0) & (unfilled != '0);

    // On flush, every unfilled slot becomes a response to throw away; a
    // response arriving in the flush cycle itself is already consumed.
    // drop_cnt + unfilled never exceeds DEPTH, so the sum fits.
    stale_sum  = drop_cnt + unfilled;
    flush_drop = stale_sum;
    if (bus.imem_rvalid_i && (stale_sum != '0)) begin
      flush_drop = stale_sum - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      ent_filled <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      drop_cnt   <= '0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (flush_i) begin
        // Flush wins over a simultaneous pop (inst_valid_o is already 0).
        ent_filled <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fill_ptr   <= '0;
        count      <= '0;
        unfilled   <= '0;
        drop_cnt   <= flush_drop;
      end else begin
        if (pop) begin
          ent_filled[rd_ptr] <= 1'b0;
          rd_ptr             <= rd_ptr + PTR_W'(1);
        end

        // fill_ptr can never equal wr_ptr while a fill is possible
        // (unfilled > 0 means that slot is allocated), and when the FIFO
        // is full a fill at the head blocks the pop that would allow an
        // issue, so fill and issue never target the same slot.
        if (fill) begin
          ent_data[fill_ptr]   <= bus.imem_rdata_i;
          ent_filled[fill_ptr] <= 1'b1;
          fill_ptr             <= fill_ptr + PTR_W'(1);
        end

        // When full with a pop, wr_ptr == rd_ptr: the slot is freed and
        // re-allocated in the same edge.
        if (issue) begin
          ent_addr[wr_ptr]   <= pc_addr_i;
          ent_filled[wr_ptr] <= 1'b0;
          wr_ptr             <= wr_ptr + PTR_W'(1);
        end

        count    <= count + CNT_W'(issue) - CNT_W'(pop);
        unfilled <= unfilled + CNT_W'(issue) - CNT_W'(fill);

        if (drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // During a flush the PC loads the jump target, so the PC is not held.
  assign fetch_hold_o     = !issue & !flush_i;

  assign bus.imem_req_o   = issue;
  assign bus.imem_addr_o  = pc_addr_i;

  assign bus.inst_valid_o = head_filled & !flush_i;
  assign bus.inst_o       = ent_data[rd_ptr];
  assign bus.inst_addr_o  = ent_addr[rd_ptr];

  assign dbg_count_o      = count;
  assign dbg_drop_cnt_o   = drop_cnt;
  assign dbg_unfilled_o   = unfilled;

  // A response with nothing to fill and nothing to drop has no owner; the
  // logic above ignores it, but it means the memory broke the protocol.
  rvalid_has_owner: assert property (
    @(posedge clk_100MHz) disable iff (!arst_n)
      !(bus.imem_rvalid_i && (drop_cnt == '0) && (unfilled == '0))
  );

endmodule
